// File: rtl/excess3_stream_decoder.sv
// Excess-3 stream decoder: accumulates MSD-first excess-3 digits into one binary result per frame.
// Latency: result registered on the end-of-frame accept edge; one bubble cycle per frame (DONE).
// Backpressure: in_ready drops while a result is pending; it is held until out_valid & out_ready.
//
// Ports:
//   CLOCK_50, RESET                 clock and synchronous active-high reset
//   in_valid/in_code/in_last/in_ready   digit input handshake (in_code = decimal digit + 3)
//   out_valid/out_ready             result handshake
//   out_value/out_count/out_error   decoded value, digits in frame, any-invalid-code flag
module excess3_stream_decoder #(
  parameter int DIGITS = 4,
  parameter int VW     = 14,
  parameter int CW     = 3
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  input  logic          in_valid,
  input  logic [3:0]    in_code,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] out_value,
  output logic [CW-1:0] out_count,
  output logic          out_error
);

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  state_t        state;
  logic [VW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          err;

  logic          accept;
  logic          code_ok;
  logic [3:0]    digit;
  logic [VW-1:0] acc_next;
  logic [CW-1:0] cnt_next;
  logic          err_next;
  logic          eof;

  // in_ready is a register that mirrors state == ACC, so accept has no
  // combinational dependence on anything but in_valid.
  assign accept   = in_valid & in_ready;
  assign code_ok  = (in_code >= 4'd3) && (in_code <= 4'd12);
  assign digit    = code_ok ? (in_code - 4'd3) : 4'd0;
  // acc*10 built as acc*8 + acc*2; truncation to VW bits cannot lose
  // information as long as 2^VW exceeds the largest DIGITS-digit value.
  assign acc_next = (acc << 3) + (acc << 1) + {{(VW-4){1'b0}}, digit};
  assign cnt_next = cnt + CW'(1);
  assign err_next = err | ~code_ok;
  // in_last on the digit that also fills the frame is one end of frame.
  assign eof      = in_last || (cnt_next == CW'(DIGITS));

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= ACC;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_value <= '0;
      out_count <= '0;
      out_error <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            err <= err_next;
            if (eof) begin
              out_value <= acc_next;
              out_count <= cnt_next;
              out_error <= err_next;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            // Result registers keep their last contents; only out_valid drops.
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            state     <= ACC;
          end
        end
        default: begin
          state     <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
